// File: rtl/obi_mem_arbiter.sv
// obi_mem_arbiter: shares one OBI memory port between the instruction and data
// interfaces of the core. Address phases are arbitrated round-robin. A stalled
// address phase stays locked to its requester until the memory grants it.
// Responses are steered back through an ordered ID FIFO of in-flight transactions.
module obi_mem_arbiter #(
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,

    input  logic        instr_req_i,
    output logic        instr_gnt_o,
    input  logic [31:0] instr_addr_i,
    output logic        instr_rvalid_o,
    output logic [31:0] instr_rdata_o,

    input  logic        data_req_i,
    output logic        data_gnt_o,
    input  logic [31:0] data_addr_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,

    output logic        mem_req_o,
    input  logic        mem_gnt_i,
    output logic [31:0] mem_addr_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,

    output logic        err_o
);

    localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTSTANDING - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(MAX_OUTSTANDING);

    // Requester identifiers as stored in the ID FIFO and round-robin pointer.
    localparam logic SEL_DATA  = 1'b0;
    localparam logic SEL_INSTR = 1'b1;

    logic                       lock_q, lock_d;
    logic                       lockSel_q, lockSel_d;
    logic                       rrPrio_q, rrPrio_d;
    logic [MAX_OUTSTANDING-1:0] idFifo_q, idFifo_d;
    logic [PTR_W-1:0]           wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0]           rdPtr_q, rdPtr_d;
    logic [CNT_W-1:0]           count_q, count_d;
    logic                       err_q, err_d;

    logic sel;
    logic selReq;
    logic fifoFull;
    logic fifoEmpty;
    logic accept;
    logic pop;
    logic headId;

    // Pick the requester that owns the shared port this cycle: a stalled
    // address phase keeps its owner, otherwise a lone requester wins and a
    // tie goes to whoever the round-robin pointer favours.
    always_comb begin
        sel = SEL_DATA;
        if (lock_q) begin
            sel = lockSel_q;
        end else if (instr_req_i && data_req_i) begin
            sel = rrPrio_q;
        end else if (instr_req_i) begin
            sel = SEL_INSTR;
        end else begin
            sel = SEL_DATA;
        end
    end

    // Full is judged on registered occupancy only, so a response arriving in
    // the same cycle never opens the request path combinationally.
    assign fifoFull  = (count_q == CNT_FULL);
    assign fifoEmpty = (count_q == '0);

    assign selReq      = (sel == SEL_INSTR) ? instr_req_i : data_req_i;
    assign mem_req_o   = selReq & ~fifoFull;
    assign mem_addr_o  = (sel == SEL_INSTR) ? instr_addr_i : data_addr_i;
    assign mem_we_o    = (sel == SEL_INSTR) ? 1'b0 : data_we_i;
    assign mem_be_o    = (sel == SEL_INSTR) ? 4'hF : data_be_i;
    assign mem_wdata_o = (sel == SEL_INSTR) ? 32'h0 : data_wdata_i;

    assign accept      = mem_req_o & mem_gnt_i;
    assign instr_gnt_o = accept & (sel == SEL_INSTR);
    assign data_gnt_o  = accept & (sel == SEL_DATA);

    // Responses come back in order, so the FIFO head names their owner.
    assign pop            = mem_rvalid_i & ~fifoEmpty;
    assign headId         = idFifo_q[rdPtr_q];
    assign instr_rvalid_o = pop & (headId == SEL_INSTR);
    assign data_rvalid_o  = pop & (headId == SEL_DATA);
    assign instr_rdata_o  = mem_rdata_i;
    assign data_rdata_o   = mem_rdata_i;

    assign err_o = err_q;

    // Next-state for lock, round-robin pointer, ID FIFO and the sticky error.
    always_comb begin
        lock_d    = lock_q;
        lockSel_d = lockSel_q;
        rrPrio_d  = rrPrio_q;
        idFifo_d  = idFifo_q;
        wrPtr_d   = wrPtr_q;
        rdPtr_d   = rdPtr_q;
        count_d   = count_q;
        err_d     = err_q;

        if (mem_gnt_i) begin
            lock_d = 1'b0;
        end else if (mem_req_o) begin
            lock_d    = 1'b1;
            lockSel_d = sel;
        end

        if (accept) begin
            idFifo_d[wrPtr_q] = sel;
            wrPtr_d  = (wrPtr_q == PTR_LAST) ? '0 : wrPtr_q + 1'b1;
            rrPrio_d = ~sel;
        end

        if (pop) begin
            rdPtr_d = (rdPtr_q == PTR_LAST) ? '0 : rdPtr_q + 1'b1;
        end

        if (mem_rvalid_i && fifoEmpty) begin
            err_d = 1'b1;
        end

        case ({accept, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // State registers with synchronous reset; data is favoured first after reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lock_q    <= 1'b0;
            lockSel_q <= SEL_DATA;
            rrPrio_q  <= SEL_DATA;
            idFifo_q  <= '0;
            wrPtr_q   <= '0;
            rdPtr_q   <= '0;
            count_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            lock_q    <= lock_d;
            lockSel_q <= lockSel_d;
            rrPrio_q  <= rrPrio_d;
            idFifo_q  <= idFifo_d;
            wrPtr_q   <= wrPtr_d;
            rdPtr_q   <= rdPtr_d;
            count_q   <= count_d;
            err_q     <= err_d;
        end
    end

endmodule

// File: tb/tb_obi_mem_arbiter.sv
// tb_obi_mem_arbiter: randomized traffic from both requesters and a memory
// model, checked against a behavioural arbiter model and a response scoreboard.
module tb_obi_mem_arbiter;

    localparam int MAXO = 2;

    logic        clk_i;
    logic        rst_i;
    logic        instr_req_i;
    logic        instr_gnt_o;
    logic [31:0] instr_addr_i;
    logic        instr_rvalid_o;
    logic [31:0] instr_rdata_o;
    logic        data_req_i;
    logic        data_gnt_o;
    logic [31:0] data_addr_i;
    logic        data_we_i;
    logic [3:0]  data_be_i;
    logic [31:0] data_wdata_i;
    logic        data_rvalid_o;
    logic [31:0] data_rdata_o;
    logic        mem_req_o;
    logic        mem_gnt_i;
    logic [31:0] mem_addr_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_wdata_o;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic        err_o;

    typedef struct {
        bit          isInstr;
        logic [31:0] data;
    } resp_t;

    resp_t       sb[$];
    logic [31:0] memPending[$];
    resp_t       monEntry;

    int checks = 0;
    int errors = 0;

    int  modelCnt = 0;
    bit  modelLock = 0;
    bit  modelLockOwner = 0;
    bit  modelPrio = 0;
    bit  modelErr = 0;
    bit  lastInstrGnt = 0;
    bit  lastDataGnt = 0;

    obi_mem_arbiter #(.MAX_OUTSTANDING(MAXO)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .instr_req_i    (instr_req_i),
        .instr_gnt_o    (instr_gnt_o),
        .instr_addr_i   (instr_addr_i),
        .instr_rvalid_o (instr_rvalid_o),
        .instr_rdata_o  (instr_rdata_o),
        .data_req_i     (data_req_i),
        .data_gnt_o     (data_gnt_o),
        .data_addr_i    (data_addr_i),
        .data_we_i      (data_we_i),
        .data_be_i      (data_be_i),
        .data_wdata_i   (data_wdata_i),
        .data_rvalid_o  (data_rvalid_o),
        .data_rdata_o   (data_rdata_o),
        .mem_req_o      (mem_req_o),
        .mem_gnt_i      (mem_gnt_i),
        .mem_addr_o     (mem_addr_o),
        .mem_we_o       (mem_we_o),
        .mem_be_o       (mem_be_o),
        .mem_wdata_o    (mem_wdata_o),
        .mem_rvalid_i   (mem_rvalid_i),
        .mem_rdata_i    (mem_rdata_i),
        .err_o          (err_o)
    );

    // Free-running clock, 10 time units per cycle.
    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    // Memory read data is a fixed scramble of the address, so the scoreboard
    // can predict it at grant time.
    function automatic logic [31:0] respData(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // One cycle of stimulus. Requesters hold req and attributes until granted;
    // the memory answers pending transactions in order at random.
    task automatic applyStimulus(input bit allowNew, input bit spurious);
        @(posedge clk_i);
        #1;
        if (!(instr_req_i && !lastInstrGnt)) begin
            instr_req_i  = allowNew && ($urandom_range(0, 9) < 7);
            instr_addr_i = $urandom & 32'hFFFF_FFFC;
        end
        if (!(data_req_i && !lastDataGnt)) begin
            data_req_i   = allowNew && ($urandom_range(0, 9) < 7);
            data_addr_i  = $urandom;
            data_we_i    = 1'($urandom);
            data_be_i    = 4'($urandom);
            data_wdata_i = $urandom;
        end
        mem_gnt_i = ($urandom_range(0, 9) < 6);
        if (spurious) begin
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = $urandom;
        end else if (memPending.size() > 0 && $urandom_range(0, 1) == 1) begin
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = respData(memPending.pop_front());
        end else begin
            mem_rvalid_i = 1'b0;
            mem_rdata_i  = $urandom;
        end
    endtask

    task automatic doReset();
        @(posedge clk_i);
        #1;
        rst_i        = 1'b1;
        instr_req_i  = 1'b0;
        data_req_i   = 1'b0;
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
    endtask

    // Behavioural arbiter model: checks the address-phase outputs and the
    // error flag each cycle, and records every grant for the scoreboard.
    always begin
        bit          who;
        bit          full;
        bit          reqExp;
        bit          grantExp;
        logic [31:0] addrExp;
        @(negedge clk_i);
        #1;
        if (rst_i) begin
            modelCnt       = 0;
            modelLock      = 0;
            modelLockOwner = 0;
            modelPrio      = 0;
            modelErr       = 0;
            lastInstrGnt   = 0;
            lastDataGnt    = 0;
            sb.delete();
            memPending.delete();
        end else begin
            full = (modelCnt >= MAXO);
            if (modelLock)                       who = modelLockOwner;
            else if (instr_req_i && data_req_i)  who = modelPrio;
            else                                 who = instr_req_i;
            reqExp   = (who ? instr_req_i : data_req_i) && !full;
            grantExp = reqExp && mem_gnt_i;
            addrExp  = who ? instr_addr_i : data_addr_i;

            checkOutput("mem_req", {31'b0, mem_req_o}, {31'b0, reqExp});
            checkOutput("instr_gnt", {31'b0, instr_gnt_o}, {31'b0, grantExp && who});
            checkOutput("data_gnt", {31'b0, data_gnt_o}, {31'b0, grantExp && !who});
            checkOutput("err", {31'b0, err_o}, {31'b0, modelErr});
            if (reqExp) begin
                checkOutput("mem_addr", mem_addr_o, addrExp);
                checkOutput("mem_we", {31'b0, mem_we_o}, {31'b0, who ? 1'b0 : data_we_i});
                checkOutput("mem_be", {28'b0, mem_be_o}, {28'b0, who ? 4'hF : data_be_i});
                checkOutput("mem_wdata", mem_wdata_o, who ? 32'h0 : data_wdata_i);
            end

            if (mem_rvalid_i) begin
                if (modelCnt > 0) modelCnt--;
                else              modelErr = 1;
            end
            if (grantExp) begin
                modelCnt++;
                modelPrio = !who;
                sb.push_back('{who, respData(addrExp)});
                memPending.push_back(addrExp);
            end
            if (mem_gnt_i)   modelLock = 0;
            else if (reqExp) begin
                modelLock      = 1;
                modelLockOwner = who;
            end
            lastInstrGnt = grantExp && who;
            lastDataGnt  = grantExp && !who;
        end
    end

    // Response monitor: every steered rvalid must match the oldest granted
    // transaction, and a memory response with work in flight must be delivered.
    always @(negedge clk_i) begin
        if (!rst_i && (instr_rvalid_o || data_rvalid_o || mem_rvalid_i)) begin
            if (instr_rvalid_o && data_rvalid_o) begin
                checks++;
                errors++;
                $display("[TB] FAIL rvalid_both: got instr=1 data=1 expected one-hot at %0t", $time);
            end else if (instr_rvalid_o || data_rvalid_o) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL rvalid_unexpected: got instr=%0b data=%0b expected none at %0t",
                             instr_rvalid_o, data_rvalid_o, $time);
                end else begin
                    monEntry = sb.pop_front();
                    checkOutput("rvalid_route", {31'b0, instr_rvalid_o}, {31'b0, monEntry.isInstr});
                    checkOutput("rdata", instr_rvalid_o ? instr_rdata_o : data_rdata_o, monEntry.data);
                end
            end else begin
                checks++;
                if (sb.size() != 0) begin
                    errors++;
                    $display("[TB] FAIL rvalid_missing: got none expected %s rvalid at %0t",
                             sb[0].isInstr ? "instr" : "data", $time);
                end
            end
        end
    end

    // Test sequence: reset, random traffic, mid-flight reset, more traffic,
    // drain, spurious response, final reset.
    initial begin
        rst_i        = 1'b1;
        instr_req_i  = 1'b0;
        instr_addr_i = 32'h0;
        data_req_i   = 1'b0;
        data_addr_i  = 32'h0;
        data_we_i    = 1'b0;
        data_be_i    = 4'h0;
        data_wdata_i = 32'h0;
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = 32'h0;
        repeat (3) @(posedge clk_i);
        #1;
        rst_i = 1'b0;

        repeat (1500) applyStimulus(1'b1, 1'b0);
        doReset();
        repeat (1000) applyStimulus(1'b1, 1'b0);

        for (int i = 0; i < 300 && (memPending.size() > 0 || instr_req_i || data_req_i); i++) begin
            applyStimulus(1'b0, 1'b0);
        end
        applyStimulus(1'b0, 1'b0);
        checkOutput("drain_sb", sb.size(), 0);
        checkOutput("drain_mem", memPending.size(), 0);

        applyStimulus(1'b0, 1'b1);
        repeat (20) applyStimulus(1'b1, 1'b0);
        doReset();
        repeat (3) applyStimulus(1'b0, 1'b0);

        @(negedge clk_i);
        #2;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
